// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops, an iterative radix-2 multiply and an
// architectural counter register, delivered through a registered valid/ready output.
module alu_exec #(
    parameter int XLEN = 64,
    parameter int SHW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      alu_control,
    input  logic            regwrite_control,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [XLEN-1:0] result,
    output logic            regwrite_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            illegal_op,
    output logic            busy,
    output logic [XLEN-1:0] counter_value,
    output logic [1:0]      fsm_state
);
    // Handshake: a command transfers on a rising edge where in_valid & in_ready;
    // a result transfers on a rising edge where out_valid & out_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [SHW:0] MUL_STEPS = (SHW + 1)'(XLEN);

    state_t          state;
    logic [XLEN-1:0] counter;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic [XLEN-1:0] acc;
    logic [SHW:0]    count;
    logic            mul_regwrite;

    logic            accept;
    logic            is_mul;
    logic            legal;
    logic            counter_load;
    logic [XLEN-1:0] counter_next;
    logic [XLEN-1:0] op_result;
    logic [SHW-1:0]  shamt;

    assign fsm_state     = state;
    assign counter_value = counter;
    assign in_ready      = (state == IDLE) || (state == HOLD && out_ready);
    assign accept        = in_valid && in_ready;
    assign is_mul        = (alu_control == 8'h03);
    assign legal         = (alu_control >= 8'h01) && (alu_control <= 8'h0F);
    assign shamt         = operand_b[SHW-1:0];

    always_comb begin
        op_result    = '0;
        counter_next = counter;
        counter_load = 1'b0;
        case (alu_control)
            8'h01: op_result = operand_a + operand_b;
            8'h02: op_result = operand_a - operand_b;
            8'h04: op_result = operand_a & operand_b;
            8'h05: op_result = operand_a | operand_b;
            8'h06: op_result = ~operand_a;
            8'h07: op_result = operand_a ^ operand_b;
            8'h08: op_result = operand_a << shamt;
            8'h09: op_result = operand_a >> shamt;
            8'h0A: op_result = {{(XLEN-1){1'b0}}, operand_a > operand_b};
            8'h0B: op_result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            8'h0C: op_result = {{(XLEN-1){1'b0}}, operand_a == operand_b};
            8'h0D: begin
                counter_next = operand_a;
                counter_load = 1'b1;
                op_result    = operand_a;
            end
            8'h0E: begin
                counter_next = counter + 1'b1;
                counter_load = 1'b1;
                op_result    = counter + 1'b1;
            end
            8'h0F: begin
                counter_next = counter - 1'b1;
                counter_load = 1'b1;
                op_result    = counter - 1'b1;
            end
            default: op_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            result       <= '0;
            regwrite_out <= 1'b0;
            out_valid    <= 1'b0;
            illegal_op   <= 1'b0;
            busy         <= 1'b0;
            counter      <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            acc          <= '0;
            count        <= '0;
            mul_regwrite <= 1'b0;
        end else if (state == MUL) begin
            // XLEN shift-add steps, then one extra edge to publish the product.
            if (count == MUL_STEPS) begin
                result       <= acc;
                regwrite_out <= mul_regwrite;
                illegal_op   <= 1'b0;
                out_valid    <= 1'b1;
                busy         <= 1'b0;
                state        <= HOLD;
            end else begin
                acc   <= acc + (mul_b[0] ? mul_a : '0);
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                count <= count + 1'b1;
            end
        end else if (accept) begin
            if (is_mul) begin
                mul_a        <= operand_a;
                mul_b        <= operand_b;
                acc          <= '0;
                count        <= '0;
                mul_regwrite <= regwrite_control;
                busy         <= 1'b1;
                out_valid    <= 1'b0;
                state        <= MUL;
            end else begin
                result       <= op_result;
                regwrite_out <= legal && regwrite_control;
                illegal_op   <= !legal;
                out_valid    <= 1'b1;
                state        <= HOLD;
                if (counter_load) begin
                    counter <= counter_next;
                end
            end
        end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: ALU ops, multiply timing, reset abort,
// counter wrap, backpressure and illegal codes.
module tb_alu_exec;
    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      alu_control;
    logic            regwrite_control;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] result;
    logic            regwrite_out;
    logic            out_valid;
    logic            out_ready;
    logic            illegal_op;
    logic            busy;
    logic [XLEN-1:0] counter_value;
    logic [1:0]      fsm_state;

    int checks = 0;
    int errors = 0;

    alu_exec #(.XLEN(XLEN), .SHW(6)) dut (
        .clk(clk), .reset(reset), .alu_control(alu_control),
        .regwrite_control(regwrite_control), .operand_a(operand_a),
        .operand_b(operand_b), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .regwrite_out(regwrite_out), .out_valid(out_valid),
        .out_ready(out_ready), .illegal_op(illegal_op), .busy(busy),
        .counter_value(counter_value), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one command for one edge; returns at the following negedge.
    task automatic send(input logic [7:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic rw);
        alu_control      = op;
        operand_a        = a;
        operand_b        = b;
        regwrite_control = rw;
        in_valid         = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [XLEN-1:0] exp_res,
                             input logic exp_rw, input logic exp_ill);
        check({tag, "_valid"}, XLEN'(out_valid), XLEN'(1'b1));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_regwrite"}, XLEN'(regwrite_out), XLEN'(exp_rw));
        check({tag, "_illegal"}, XLEN'(illegal_op), XLEN'(exp_ill));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_control = 8'h00; regwrite_control = 1'b0;
        operand_a = '0; operand_b = '0;
        step(); step();
        check("rst_valid", XLEN'(out_valid), '0);
        check("rst_result", result, '0);
        check("rst_busy", XLEN'(busy), '0);
        check("rst_counter", counter_value, '0);
        check("rst_state", XLEN'(fsm_state), '0);
        check("rst_regwrite", XLEN'(regwrite_out), '0);
        check("rst_illegal", XLEN'(illegal_op), '0);
        reset = 1'b0;
        step();
        check("idle_in_ready", XLEN'(in_ready), XLEN'(1'b1));

        // Single-cycle ops, back-to-back while out_ready stays high
        send(8'h01, 64'd5, 64'd7, 1'b1);
        check_out("add", 64'd12, 1'b1, 1'b0);
        send(8'h02, 64'd0, 64'd1, 1'b1);
        check_out("sub", ONES, 1'b1, 1'b0);
        send(8'h08, 64'd1, 64'h41, 1'b1);
        check_out("shl", 64'd2, 1'b1, 1'b0);
        send(8'h09, 64'h80, 64'd3, 1'b1);
        check_out("shr", 64'h10, 1'b1, 1'b0);
        send(8'h05, 64'hF0, 64'h0F, 1'b0);
        check_out("or_norw", 64'hFF, 1'b0, 1'b0);
        send(8'h06, 64'h0, 64'h0, 1'b1);
        check_out("not", ONES, 1'b1, 1'b0);
        send(8'h0A, 64'd5, 64'd3, 1'b1);
        check_out("gt", 64'd1, 1'b1, 1'b0);
        send(8'h0B, 64'd5, 64'd3, 1'b1);
        check_out("lt", 64'd0, 1'b1, 1'b0);
        send(8'h0C, 64'd9, 64'd9, 1'b1);
        check_out("eq", 64'd1, 1'b1, 1'b0);
        step();
        check("drain_valid", XLEN'(out_valid), '0);

        // Multiply: busy, in_ready low, operands scrambled, result at accept+65
        send(8'h03, 64'hFFFF_FFFF, 64'h1_0000_0001, 1'b1);
        operand_a = 64'h1234_5678_9ABC_DEF0;
        operand_b = 64'h0FED_CBA9_8765_4321;
        begin
            int bad_busy = 0;
            int bad_ready = 0;
            int bad_valid = 0;
            for (int k = 1; k <= 64; k++) begin
                if (busy !== 1'b1) bad_busy++;
                if (in_ready !== 1'b0) bad_ready++;
                if (out_valid !== 1'b0) bad_valid++;
                step();
            end
            check("mul_busy_bad", XLEN'(bad_busy), '0);
            check("mul_in_ready_bad", XLEN'(bad_ready), '0);
            check("mul_early_valid_bad", XLEN'(bad_valid), '0);
        end
        check("mul_valid_at_64", XLEN'(out_valid), '0);
        step();
        check_out("mul", ONES, 1'b1, 1'b0);
        check("mul_busy_done", XLEN'(busy), '0);
        step();

        // Reset during a second multiply discards it
        send(8'h03, 64'd3, 64'd5, 1'b1);
        for (int k = 0; k < 29; k++) step();
        check("mul2_busy", XLEN'(busy), XLEN'(1'b1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        begin
            int bad_valid = 0;
            for (int k = 0; k < 70; k++) begin
                if (out_valid !== 1'b0) bad_valid++;
                step();
            end
            check("abort_valid_bad", XLEN'(bad_valid), '0);
        end
        check("abort_state", XLEN'(fsm_state), '0);
        check("abort_busy", XLEN'(busy), '0);

        // Counter load and wrap
        send(8'h0D, ONES - 64'd1, 64'd0, 1'b1);
        check_out("cnt_load", ONES - 64'd1, 1'b1, 1'b0);
        check("cnt_load_value", counter_value, ONES - 64'd1);
        send(8'h0E, 64'd0, 64'd0, 1'b1);
        check_out("cnt_inc1", ONES, 1'b1, 1'b0);
        send(8'h0E, 64'd0, 64'd0, 1'b1);
        check_out("cnt_inc2", 64'd0, 1'b1, 1'b0);
        check("cnt_wrap_value", counter_value, 64'd0);
        send(8'h0F, 64'd0, 64'd0, 1'b1);
        check_out("cnt_dec", ONES, 1'b1, 1'b0);
        step();

        // Backpressure then release with a pending XOR
        out_ready = 1'b0;
        send(8'h04, 64'hF0F0, 64'hFF00, 1'b1);
        check_out("and", 64'hF000, 1'b1, 1'b0);
        alu_control = 8'h07; operand_a = 64'hFF; operand_b = 64'h0F;
        regwrite_control = 1'b1; in_valid = 1'b1;
        check("bp_in_ready", XLEN'(in_ready), '0);
        step(); step();
        check_out("bp_hold", 64'hF000, 1'b1, 1'b0);
        check("bp_state", XLEN'(fsm_state), 64'd2);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", XLEN'(in_ready), XLEN'(1'b1));
        step();
        in_valid = 1'b0;
        check_out("xor", 64'hF0, 1'b1, 1'b0);
        step();
        check("xor_drain", XLEN'(out_valid), '0);

        // Illegal codes leave the counter alone
        send(8'h00, 64'd5, 64'd7, 1'b1);
        check_out("ill_00", 64'd0, 1'b0, 1'b1);
        send(8'h20, 64'd5, 64'd7, 1'b1);
        check_out("ill_20", 64'd0, 1'b0, 1'b1);
        check("ill_counter", counter_value, ONES);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
